// File: rtl/excess3_pkg.sv
// Shared constants and state encoding for the excess-3 to BCD decoder.
package excess3_pkg;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] EX3_MIN    = 4'd3;
  localparam logic [3:0] EX3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/excess3_digit_dec.sv
// Combinational single-digit excess-3 to BCD decoder with invalid-code flag.
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    err = (code < EX3_MIN) || (code > EX3_MAX);
    bcd = err ? 4'd0 : (code - EX3_OFFSET);
  end

endmodule

// File: rtl/excess3_to_bcd_seq.sv
// Serial multi-digit excess-3 to BCD decoder: one digit per clock, LSD first,
// result held under valid/ready until consumed.
module excess3_to_bcd_seq
  import excess3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t                state_q;
  logic [4*DIGITS-1:0]   shift_q;
  logic [4*DIGITS-1:0]   work_bcd_q;
  logic [4*DIGITS-1:0]   work_bcd_d;
  logic [DIGITS-1:0]     work_mask_q;
  logic [DIGITS-1:0]     work_mask_d;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            dig_bcd;
  logic                  dig_err;
  logic                  accept;

  excess3_digit_dec u_dec (
    .code (shift_q[3:0]),
    .bcd  (dig_bcd),
    .err  (dig_err)
  );

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  // Working registers with the current digit merged in, so the final edge can
  // publish a complete result.
  always_comb begin
    work_bcd_d  = work_bcd_q;
    work_mask_d = work_mask_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt_q == CW'(i)) begin
        work_bcd_d[4*i +: 4] = dig_bcd;
        work_mask_d[i]       = dig_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      work_bcd_q   <= '0;
      work_mask_q  <= '0;
      cnt_q        <= '0;
      out_bcd      <= '0;
      out_err_mask <= '0;
      out_err      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            shift_q     <= in_code;
            work_bcd_q  <= '0;
            work_mask_q <= '0;
            cnt_q       <= '0;
            state_q     <= CONV;
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        CONV: begin
          shift_q     <= shift_q >> 4;
          work_bcd_q  <= work_bcd_d;
          work_mask_q <= work_mask_d;
          if (cnt_q == LAST) begin
            cnt_q        <= '0;
            out_bcd      <= work_bcd_d;
            out_err_mask <= work_mask_d;
            out_err      <= |work_mask_d;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_seq.sv
// Directed self-checking bench for excess3_to_bcd_seq with DIGITS=4.
module tb_excess3_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic        out_err;
  logic [3:0]  out_err_mask;

  int checks = 0;
  int fails  = 0;

  excess3_to_bcd_seq #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one word from IDLE with out_ready low; lat = edges after the accept
  // edge until out_valid, or -1 if it never rises within budget.
  task automatic run_word(input logic [15:0] code, output int lat);
    in_code  = code;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_code  = 16'h0000;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_code   = 16'h4C63;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0) begin
        fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_bcd !== 16'h0000 || out_err_mask !== 4'b0000 || out_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: bcd %h mask %b err %b want 0000 0000 0",
                 out_bcd, out_err_mask, out_err);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_no_word: out_valid %b want 0 at cycle %0d", out_valid, i);
      end
    end
  endtask

  task automatic test_nominal();
    int lat;
    run_word(16'h4C63, lat);
    checks++;
    if (lat != 4) begin
      fails++; $display("FAIL nominal_latency: got %0d want 4", lat);
    end
    checks++;
    if (out_bcd !== 16'h1930 || out_err !== 1'b0 || out_err_mask !== 4'b0000) begin
      fails++;
      $display("FAIL nominal_result: bcd %h err %b mask %b want 1930 0 0000",
               out_bcd, out_err, out_err_mask);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || out_bcd !== 16'h1930) begin
      fails++;
      $display("FAIL nominal_consume: valid %b bcd %h want 0 1930", out_valid, out_bcd);
    end
  endtask

  task automatic test_invalid();
    int lat;
    logic [3:0] exp_bcd [16];
    logic       exp_err [16];
    exp_bcd = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0, 4'd0};
    exp_err = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_word(16'h5F93, lat);
    checks++;
    if (lat != 4 || out_bcd !== 16'h2060 || out_err_mask !== 4'b0100 || out_err !== 1'b1) begin
      fails++;
      $display("FAIL invalid_word: lat %0d bcd %h mask %b err %b want 4 2060 0100 1",
               lat, out_bcd, out_err_mask, out_err);
    end
    consume();
    for (int c = 0; c < 16; c++) begin
      run_word({12'h333, 4'(c)}, lat);
      checks++;
      if (lat != 4 || out_bcd !== {12'h000, exp_bcd[c]} ||
          out_err_mask !== {3'b000, exp_err[c]} || out_err !== exp_err[c]) begin
        fails++;
        $display("FAIL sweep_code_%0d: lat %0d bcd %h mask %b err %b want 4 %h %b %b",
                 c, lat, out_bcd, out_err_mask, out_err, {12'h000, exp_bcd[c]},
                 {3'b000, exp_err[c]}, exp_err[c]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_word(16'h4C63, lat);
    in_valid  = 1'b1;
    in_code   = 16'h3333;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 16'h1930 ||
          out_err_mask !== 4'b0000) begin
        fails++;
        $display("FAIL backpressure_hold: valid %b ready %b bcd %h mask %b want 1 0 1930 0000",
                 out_valid, in_ready, out_bcd, out_err_mask);
      end
    end
    in_valid = 1'b0;
    consume();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_bcd !== 16'h1930) begin
        fails++;
        $display("FAIL backpressure_not_taken: valid %b bcd %h want 0 1930", out_valid, out_bcd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_word(16'h4C63, lat);
    in_valid  = 1'b1;
    in_code   = 16'hCCCC;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready: got %b want 1", in_ready);
    end
    step();
    in_valid  = 1'b0;
    in_code   = 16'h0000;
    out_ready = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_bcd !== 16'h1930) begin
        fails++;
        $display("FAIL b2b_hold_edge%0d: valid %b bcd %h want 0 1930", e, out_valid, out_bcd);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_bcd !== 16'h9999 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_result: valid %b bcd %h err %b want 1 9999 0", out_valid, out_bcd, out_err);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_code  = 16'h4C63;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bcd !== 16'h0000 || out_err_mask !== 4'b0000 ||
        in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_state: valid %b bcd %h mask %b ready %b want 0 0000 0000 1",
               out_valid, out_bcd, out_err_mask, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL midreset_no_output: valid %b want 0 at cycle %0d", out_valid, i);
      end
    end
    run_word(16'h3456, lat);
    checks++;
    if (lat != 4 || out_bcd !== 16'h0123 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_next_word: lat %0d bcd %h err %b want 4 0123 0", lat, out_bcd, out_err);
    end
    consume();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 16'h0000;
    out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/excess3_to_bcd_seq.md
Name: excess3_to_bcd_seq

Overview:
Multi-digit excess-3 to BCD decoder and the receive-side counterpart of the team's BCD-to-excess-3 encoder. It accepts a packed word of DIGITS excess-3 codes over a valid/ready handshake and decodes one digit per clock, least significant first. It presents the packed BCD result with per-digit invalid-code flags and holds it until the consumer accepts it. It sits between an excess-3 source (link or storage) and BCD arithmetic or display logic.

Parameters:
DIGITS, 4, number of 4-bit digits per word (legal range 1..16)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  producer has a word on in_code
in_ready  output  1  block can accept a word this cycle
in_code  input  4*DIGITS  packed excess-3 digits; digit 0 = bits [3:0]
out_valid  output  1  result on out_bcd/out_err/out_err_mask is valid
out_ready  input  1  consumer accepts the result this cycle
out_bcd  output  4*DIGITS  packed BCD result; digit 0 = bits [3:0]
out_err  output  1  OR of out_err_mask
out_err_mask  output  DIGITS  bit i set = digit i of the word was an invalid excess-3 code

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; out_valid=0; out_bcd=0; out_err=0; out_err_mask=0; digit counter=0; working registers cleared. Reset wins over every other event. An in-flight word is discarded and produces no output.
- Digit decode: code 0011..1100 gives BCD = code - 3 (4-bit subtract), no error. Codes 0000..0010 and 1101..1111 are invalid: BCD digit forced to 0000 and the mask bit set.
- States IDLE, CONV, DONE.
- in_ready is combinational: 1 in IDLE, or in DONE when out_ready=1. It is 0 in CONV and always 0 while rst_n=0.
- Accept edge (in_valid & in_ready): capture in_code into the shift register, clear the working BCD and mask, counter=0, go to CONV.
- CONV, each edge:
  - Decode shift register bits [3:0] and write the result into working digit position [counter].
  - Shift the register right by 4; counter+1.
  - On the edge that processes digit DIGITS-1: load out_bcd, out_err_mask and out_err from the working registers (including the digit just decoded), set out_valid=1, go to DONE.
- Latency: out_valid rises exactly DIGITS edges after the accept edge. With DIGITS=1, it is the edge after accept.
- DONE: out_valid=1; all outputs stable.
  - out_ready=1, in_valid=0: out_valid=0, go to IDLE.
  - out_ready=1, in_valid=1: result consumed and new word accepted on the same edge; out_valid=0, go to CONV.
  - out_ready=0: hold indefinitely. in_valid is ignored.
- out_bcd, out_err and out_err_mask change only on the edge entering DONE or on reset. They keep the previous result through IDLE and CONV.
- in_code is sampled only on the accept edge; later changes have no effect.
- out_ready outside DONE is ignored.
- Sustained throughput: one word per DIGITS+1 cycles.
- Width rules: counter width is clog2(DIGITS) with a minimum of 1 bit. No arithmetic wider than 4 bits.

Decomposition:
- Package excess3_pkg holds:
  - EX3_OFFSET = 4'd3, EX3_MIN = 4'd3, EX3_MAX = 4'd12
  - state typedef {IDLE, CONV, DONE}
- Sub-module excess3_digit_dec (combinational): 4-bit code in; 4-bit BCD and 1-bit err out. Instantiated once and shared across digits by the serial datapath.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_code=16'h4C63 -> in_ready=0 and out_valid=0 throughout; out_bcd=0, out_err_mask=0; after release, in_ready=1 and no word was taken.
- Nominal, DIGITS=4: accept 16'h4C63 -> out_valid rises exactly 4 edges after accept; out_bcd=16'h1930, out_err=0, out_err_mask=4'b0000.
- Invalid codes: accept 16'h5F93 -> out_bcd=16'h2060, out_err_mask=4'b0100, out_err=1. Then sweep all 16 codes in digit 0: codes 3..12 map to 0..9; codes 0..2 and 13..15 give 0000 with mask bit 0 set.
- Backpressure: after a result, out_ready=0 for 10 cycles while in_valid=1 with 16'h3333 -> out_valid stays 1; outputs stable at the prior result; in_ready=0; 16'h3333 is not accepted.
- Back-to-back: in DONE with out_ready=1, in_valid=1, in_code=16'hCCCC -> both handshakes on one edge; out_bcd holds the old value for 3 edges; out_bcd=16'h9999 with out_valid=1 on the 4th edge.
- Reset mid-conversion: rst_n=0 for one edge two cycles after accepting 16'h4C63 -> out_valid never rises for that word; state IDLE; out_bcd=0; the next accepted 16'h3456 yields 16'h0123.
